// File: rtl/sigma_window_alarm_pkg.sv
// Shared definitions for the sigma window alarm: default widths, alarm
// state encoding and the log2 helper used to size the averaging window.
package sigma_pkg;

    localparam int SUM_W_DEF = 12;
    localparam int OUT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        NORMAL,
        ALARM
    } alarm_state_t;

    // Ceiling log2 for small window lengths (up to 16).
    function automatic int log2_depth(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 5; i++) begin
            if ((1 << i) < depth) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sigma_window_alarm_mavg.sv
// Moving average over the last DEPTH accepted means, kept as a shift
// register plus a running sum so each update costs one add and one subtract.
module sigma_mavg
    import sigma_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic [OUT_W-1:0] mean,
    input  logic             accept,
    output logic [OUT_W-1:0] avg,
    output logic             valid
);

    localparam int LG     = log2_depth(DEPTH);
    localparam int ACC_W  = OUT_W + LG;
    localparam int FILL_W = LG + 1;

    logic [OUT_W-1:0]  win [DEPTH];
    logic [ACC_W-1:0]  acc;
    logic [FILL_W-1:0] fill;

    // Empty slots hold zero, so the sum stays exact while the window fills.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            acc   <= '0;
            fill  <= '0;
            valid <= 1'b0;
        end else if (accept) begin
            win[0] <= mean;
            for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
            acc <= acc + ACC_W'(mean) - ACC_W'(win[DEPTH-1]);
            if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
            if (fill == FILL_W'(DEPTH - 1)) valid <= 1'b1;
        end
    end

    assign avg = OUT_W'(acc >> LG);

endmodule

// File: rtl/sigma_window_alarm.sv
// Scales strobed block sums to per-sample means, averages them over a window
// and drives a hysteretic level alarm. Define SIGMA_ROUND_EN for round-half-up scaling.
module sigma_window_alarm
    import sigma_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = 4,
    parameter int TH_HI = 200,
    parameter int TH_LO = 150,
    parameter int HOLD  = 3
) (
    input  logic             clk,
    input  logic             res,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             syn_in,
    output logic [OUT_W-1:0] mean_out,
    output logic [OUT_W-1:0] avg_out,
    output logic             syn_out,
    output logic             avg_valid,
    output logic             alarm
);

`ifdef SIGMA_ROUND_EN
    localparam int ROUND_BIAS = 8;
`else
    localparam int ROUND_BIAS = 0;
`endif
    localparam int MEAN_MAX = (1 << OUT_W) - 1;

    logic [SUM_W:0]   biased;
    logic [SUM_W:0]   shifted;
    logic [OUT_W-1:0] mean_scaled;
    logic [OUT_W-1:0] mean_s1;
    logic [OUT_W-1:0] mavg_avg;
    logic             s1_valid;
    logic             mavg_valid;
    logic             hi;
    logic             lo;
    logic [3:0]       run_cnt;
    logic [3:0]       run_inc;
    alarm_state_t     state;

    // One extra bit keeps the rounding bias from wrapping near full scale.
    assign biased      = {1'b0, sum_in} + (SUM_W+1)'(ROUND_BIAS);
    assign shifted     = biased >> 4;
    assign mean_scaled = (shifted > (SUM_W+1)'(MEAN_MAX)) ? OUT_W'(MEAN_MAX)
                                                          : shifted[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (res) begin
            s1_valid <= 1'b0;
            mean_s1  <= '0;
        end else begin
            s1_valid <= syn_in;
            if (syn_in) mean_s1 <= mean_scaled;
        end
    end

    sigma_mavg #(
        .DEPTH (DEPTH),
        .OUT_W (OUT_W)
    ) u_mavg (
        .clk    (clk),
        .res    (res),
        .mean   (mean_scaled),
        .accept (syn_in),
        .avg    (mavg_avg),
        .valid  (mavg_valid)
    );

    assign hi      = (mavg_avg >= OUT_W'(TH_HI));
    assign lo      = (mavg_avg <= OUT_W'(TH_LO));
    assign run_inc = run_cnt + 4'd1;

    // The update that fills the window leaves IDLE and is judged as NORMAL at once.
    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            run_cnt   <= '0;
            mean_out  <= '0;
            avg_out   <= '0;
            syn_out   <= 1'b0;
            avg_valid <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            syn_out <= s1_valid;
            if (s1_valid) begin
                mean_out  <= mean_s1;
                avg_out   <= mavg_avg;
                avg_valid <= mavg_valid;
                case (state)
                    IDLE, NORMAL: begin
                        if (state == NORMAL || mavg_valid) begin
                            if (!hi) begin
                                state   <= NORMAL;
                                run_cnt <= '0;
                            end else if (run_inc == 4'(HOLD)) begin
                                state   <= ALARM;
                                run_cnt <= '0;
                                alarm   <= 1'b1;
                            end else begin
                                state   <= NORMAL;
                                run_cnt <= run_inc;
                            end
                        end
                    end
                    ALARM: begin
                        if (lo) begin
                            state   <= NORMAL;
                            run_cnt <= '0;
                            alarm   <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        run_cnt <= '0;
                        alarm   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
